// File: rtl/timer_pkg.sv
// Shared types and defaults for the down_timer timing utility.
package timer_pkg;

  localparam int TIMER_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/down_count_core.sv
// WIDTH-bit count register with load, hold and decrement; load beats decrement.
// Registered output, one-cycle update latency; no flow control.
module down_count_core
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] q_o,
  output logic             is_one_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = ld_val_i;
    end else if (dec_i) begin
      q_d = q_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o      = q_q;
  assign is_one_o = (q_q == WIDTH'(1));

endmodule

// File: rtl/down_timer.sv
// Programmable down-counter with one-shot/periodic modes and a one-cycle done pulse.
// Load-to-Q latency 1 cycle; en is a count strobe, there is no backpressure.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  logic             core_ld;
  logic [WIDTH-1:0] core_val;
  logic             core_dec;
  logic             is_one;

  down_count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (core_ld),
    .ld_val_i (core_val),
    .dec_i    (core_dec),
    .q_o      (Q),
    .is_one_o (is_one)
  );

  // Priority: load > abort > decrement (rst handled in the registers).
  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    core_ld  = 1'b0;
    core_val = load_val;
    core_dec = 1'b0;

    if (load) begin
      reload_d = load_val;
      core_ld  = 1'b1;
      if (load_val != '0) begin
        state_d = RUN;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (abort) begin
      state_d = IDLE;
    end else if (state_q == RUN && en) begin
      if (is_one) begin
        done_d = 1'b1;
        if (auto_reload) begin
          // Jump straight back to the reload value so 0 is never shown.
          core_ld  = 1'b1;
          core_val = reload_q;
        end else begin
          core_dec = 1'b1;
          state_d  = IDLE;
        end
      end else begin
        core_dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer at the default width of 3.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [2:0] load_val;
  logic       en;
  logic       auto_reload;
  logic       abort;
  logic [2:0] Q;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .abort       (abort),
    .Q           (Q),
    .busy        (busy),
    .done        (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk3(input string tag, input int eq, input int eb, input int ed);
    chk({tag, ".Q"}, int'(Q), eq);
    chk({tag, ".busy"}, int'(busy), eb);
    chk({tag, ".done"}, int'(done), ed);
  endtask

  initial begin
    int exp_q;
    int prev_q;
    int exp_busy;
    int exp_done;

    rst = 1'b1; load = 1'b0; load_val = 3'd0; en = 1'b0;
    auto_reload = 1'b0; abort = 1'b0;
    step();
    step();
    chk3("reset", 0, 0, 0);
    rst = 1'b0;

    // One-shot 5: 5,4,3,2,1,0 then stays 0.
    load = 1'b1; load_val = 3'd5; en = 1'b1;
    step();
    load = 1'b0;
    chk3("os5_load", 5, 1, 0);
    for (int v = 4; v >= 1; v--) begin
      step();
      chk3("os5_cnt", v, 1, 0);
    end
    step();
    chk3("os5_expire", 0, 0, 1);
    step();
    chk3("os5_after", 0, 0, 0);

    // Periodic 3 for 10 cycles: 2,1,3,2,1,3,...
    auto_reload = 1'b1;
    load = 1'b1; load_val = 3'd3;
    step();
    load = 1'b0;
    chk3("per3_load", 3, 1, 0);
    exp_q = 3;
    for (int i = 0; i < 10; i++) begin
      prev_q   = exp_q;
      exp_q    = (prev_q == 1) ? 3 : prev_q - 1;
      exp_done = (prev_q == 1) ? 1 : 0;
      step();
      chk3("per3_cnt", exp_q, 1, exp_done);
    end

    // One-shot 7 with en gaps 1,0,0,1: expiry 9 edges after load.
    auto_reload = 1'b0;
    load = 1'b1; load_val = 3'd7;
    step();
    load = 1'b0;
    chk3("gap7_load", 7, 1, 0);
    exp_q = 7;
    for (int i = 1; i <= 9; i++) begin
      en = (i == 2 || i == 3) ? 1'b0 : 1'b1;
      if (en && exp_q > 0) exp_q--;
      exp_done = (i == 9) ? 1 : 0;
      exp_busy = (i == 9) ? 0 : 1;
      step();
      chk3("gap7_cnt", exp_q, exp_busy, exp_done);
    end
    en = 1'b1;

    // Load on the expiry edge wins: no done, restart at 6.
    load = 1'b1; load_val = 3'd2;
    step();
    load = 1'b0;
    step();
    chk3("ldx_at1", 1, 1, 0);
    load = 1'b1; load_val = 3'd6;
    step();
    load = 1'b0;
    chk3("ldx_reload", 6, 1, 0);
    step();
    chk3("ldx_resume", 5, 1, 0);

    // Abort at Q=2 then hold with en=1.
    load = 1'b1; load_val = 3'd4;
    step();
    load = 1'b0;
    step();
    step();
    chk3("ab4_at2", 2, 1, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk3("ab4_abort", 2, 0, 0);
    step();
    step();
    chk3("ab4_hold", 2, 0, 0);

    // Abort on the expiry edge suppresses done.
    load = 1'b1; load_val = 3'd1;
    step();
    load = 1'b0;
    chk3("abx_at1", 1, 1, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk3("abx_abort", 1, 0, 0);

    // Reset mid-count on the expiry edge: pending done suppressed.
    load = 1'b1; load_val = 3'd5;
    step();
    load = 1'b0;
    step();
    chk3("rst_at4", 4, 1, 0);
    load = 1'b1; load_val = 3'd1;
    step();
    load = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk3("rst_mid", 0, 0, 0);
    step();
    chk3("rst_after", 0, 0, 0);

    // Zero-length timer expires immediately.
    load = 1'b1; load_val = 3'd0;
    step();
    load = 1'b0;
    chk3("zero_load", 0, 0, 1);
    step();
    chk3("zero_after", 0, 0, 0);

    // Full-scale 7: seven decrements, no wrap below 0.
    load = 1'b1; load_val = 3'd7;
    step();
    load = 1'b0;
    for (int v = 6; v >= 1; v--) begin
      step();
      chk3("max7_cnt", v, 1, 0);
    end
    step();
    chk3("max7_expire", 0, 0, 1);
    step();
    step();
    chk3("max7_nowrap", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
